branch_resolve_unit: RTL

Resolution and update end of the dual-lane branch predictor. It carries each fetch lane's prediction metadata into decode and compares it against the actual branch outcome. On a mispredict it raises per-lane flushes and a redirect PC. Every resolved branch becomes a table write, queued in a small FIFO that drives the predictor table's single write port. It sits between the fetch-stage predictor lookup and the decode-stage branch comparators of lanes a and b.

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_update_fifo.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared widths, update record and counter helper for the branch predictor
package bp_pkg;
  localparam int IDX_BITS = 7;
  localparam int TAG_BITS = 30;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;
  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [29:0] target;
    logic [1:0] state;
  } upd_t;
  function automatic logic [1:0] next_state(logic [1:0] s, logic found, logic taken);
    return !found ? (taken ? WT : WNT) :
           taken ? (s == ST ? ST : s + 2'd1) : (s == SNT ? SNT : s - 2'd1);
  endfunction
endpackage

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: 2-write/1-read queue of predictor table updates, pops whenever non-empty
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_a,
  input  logic push_b,
  input  upd_t rec_a,
  input  upd_t rec_b,
  output upd_t head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  upd_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic pop;
  assign pop = count != '0;
  assign head = mem[rp];
  // pointer and occupancy bookkeeping; lane a always takes the first free slot
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(push_a) + PW'(push_b);
      rp <= rp + PW'(pop);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end
  // entry storage; unreset because entries are only visible while counted
  always_ff @(posedge clk) begin
    if (push_a) mem[wp] <= rec_a;
    if (push_b) mem[wp + PW'(push_a)] <= rec_b;
  end
  // the producer must honour stall_req so the queue never overflows
  assert property (@(posedge clk) disable iff (rst)
    int'(count) + int'(push_a) + int'(push_b) - int'(pop) <= DEPTH);
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves dual-lane branch predictions in decode and queues table updates
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic stall,
  input  logic [31:0] fPC,
  input  logic a_fvalid,
  input  logic b_fvalid,
  input  logic a_ffound,
  input  logic b_ffound,
  input  logic a_fhit,
  input  logic b_fhit,
  input  logic [31:0] a_fpred,
  input  logic [31:0] b_fpred,
  input  logic [1:0] a_fstate,
  input  logic [1:0] b_fstate,
  input  logic a_isBranch,
  input  logic b_isBranch,
  input  logic a_taken,
  input  logic b_taken,
  input  logic [31:0] a_pcBranchD,
  input  logic [31:0] b_pcBranchD,
  output logic redirect,
  output logic [31:0] redirectPC,
  output logic a_dflush,
  output logic b_dflush,
  output logic stall_req,
  output logic upd_valid,
  output logic [IDX_BITS-1:0] upd_idx,
  output logic [TAG_BITS-1:0] upd_tag,
  output logic [29:0] upd_target,
  output logic [1:0] upd_state
);
  logic [31:0] d_pc, a_dpred, b_dpred, pc_b, pc_b4;
  logic a_dvalid, b_dvalid, a_dfound, b_dfound, a_dhit, b_dhit;
  logic [1:0] a_dstate, b_dstate;
  logic a_mis, b_mis, push_a, push_b;
  upd_t rec_a, rec_b, head;
  logic [$clog2(FIFO_DEPTH+1)-1:0] count;
  // F->D capture; a redirect squashes whatever fetch delivered this cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_dvalid <= 1'b0;
      b_dvalid <= 1'b0;
      d_pc <= '0;
      a_dfound <= 1'b0;
      b_dfound <= 1'b0;
      a_dhit <= 1'b0;
      b_dhit <= 1'b0;
      a_dpred <= '0;
      b_dpred <= '0;
      a_dstate <= '0;
      b_dstate <= '0;
    end else if (!stall) begin
      a_dvalid <= a_fvalid && !redirect;
      b_dvalid <= b_fvalid && !redirect;
      d_pc <= fPC;
      a_dfound <= a_ffound;
      b_dfound <= b_ffound;
      a_dhit <= a_fhit;
      b_dhit <= b_fhit;
      a_dpred <= a_fpred;
      b_dpred <= b_fpred;
      a_dstate <= a_fstate;
      b_dstate <= b_fstate;
    end
  end
  // mispredict detection, redirect selection and update record formation
  always_comb begin
    pc_b = d_pc + 32'd4;
    pc_b4 = d_pc + 32'd8;
    a_mis = a_dvalid && (a_isBranch ? (a_dhit != a_taken || (a_taken && a_dpred != a_pcBranchD)) : a_dhit);
    b_mis = b_dvalid && (b_isBranch ? (b_dhit != b_taken || (b_taken && b_dpred != b_pcBranchD)) : b_dhit);
    redirect = a_mis || b_mis;
    redirectPC = a_mis ? (a_taken ? a_pcBranchD : pc_b) : b_mis ? (b_taken ? b_pcBranchD : pc_b4) : '0;
    a_dflush = a_mis;
    b_dflush = redirect;
    push_a = !stall && a_dvalid && a_isBranch;
    push_b = !stall && b_dvalid && b_isBranch && !a_mis;
    rec_a = '{idx: d_pc[IDX_BITS+1:2], tag: d_pc[31:2],
              target: a_taken ? a_pcBranchD[31:2] : pc_b[31:2],
              state: next_state(a_dstate, a_dfound, a_taken)};
    rec_b = '{idx: pc_b[IDX_BITS+1:2], tag: pc_b[31:2],
              target: b_taken ? b_pcBranchD[31:2] : pc_b4[31:2],
              state: next_state(b_dstate, b_dfound, b_taken)};
  end
  bp_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .push_a(push_a),
    .push_b(push_b),
    .rec_a(rec_a),
    .rec_b(rec_b),
    .head(head),
    .count(count)
  );
  // table write port driven from the queue head, zeroed while empty
  always_comb begin
    upd_valid = count != '0;
    upd_idx = upd_valid ? head.idx : '0;
    upd_tag = upd_valid ? head.tag : '0;
    upd_target = upd_valid ? head.target : '0;
    upd_state = upd_valid ? head.state : '0;
    stall_req = int'(count) >= FIFO_DEPTH - 1;
  end
endmodule
